imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the CPU's 32-entry instruction memory. The CPU core only reads that memory; this block fills it.
- Accepts a byte stream on a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word through the instruction-memory write port.
- Holds the CPU in reset (cpu_hold) until a complete, valid image is loaded.

Parameters:
- DEPTH_WORDS, 32, instruction-memory depth in words.
- ADDR_W, 5, word-address width; requires 2^ADDR_W >= DEPTH_WORDS.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load when idle, done or error
- in_valid  in  1  byte available
- in_data  in  8  stream byte
- in_ready  out  1  block can accept a byte
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  word to write
- cpu_hold  out  1  keep CPU in reset
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load succeeded
- error  out  1  sticky load failure
- words_loaded  out  16  count of words written in the current load

Behaviour:
- Reset values:
  - state IDLE; cpu_hold=1.
  - in_ready, imem_we, busy, done, error = 0.
  - imem_addr, imem_wdata, words_loaded = 0.
- Byte transfer occurs only when in_valid && in_ready.
- Stream format: LEN_LO, LEN_HI, then LEN words of 4 bytes each (b0 first; word = {b3,b2,b1,b0}), then CSUM.
- CSUM must equal the XOR of all preceding bytes, including the length bytes.
- State transitions:
  - IDLE: start -> LEN0; cpu_hold=1, busy=1, error cleared, words_loaded cleared, running XOR cleared.
  - LEN0 (in_ready=1): on transfer, latch the low byte -> LEN1.
  - LEN1 (in_ready=1): on transfer:
    - LEN > DEPTH_WORDS -> ERR.
    - LEN == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA (in_ready=1): a 2-bit byte counter assembles the word. On the 4th byte transfer, the next cycle drives imem_we=1 for exactly one cycle with imem_addr = word index and imem_wdata = assembled word; words_loaded increments in that same cycle. After word LEN-1 -> CHECK.
  - CHECK (in_ready=1): on transfer:
    - byte == running XOR -> DONE.
    - otherwise -> ERR.
  - DONE: done pulses one cycle on entry; cpu_hold=0 from the entry cycle onward; busy=0; in_ready=0.
  - ERR: error=1 (sticky), cpu_hold=1, busy=0, in_ready=0.
- start is ignored while busy. start in DONE or ERR restarts the load (-> LEN0, cpu_hold=1).
- in_ready may stay asserted in the cycle imem_we fires; the next word's bytes overlap the write. No throughput loss, 1 byte/cycle.
- in_valid gaps are allowed anywhere; state and partial words are held.
- Word index wraps never: LEN is bounded by the LEN1 check, so imem_addr <= DEPTH_WORDS-1.
- Reset mid-load: immediate return to IDLE, no further writes, cpu_hold=1. Words already written remain in memory (not cleared).
- Bytes arriving after DONE/ERR are not accepted (in_ready=0).

Optional Feature:
- IMEM_LOADER_CSUM_EN defined: CHECK state and checksum verification as above.
- Not defined:
  - no CSUM byte.
  - after the last word's 4th byte -> DONE directly (done pulses in the imem_we cycle; cpu_hold falls that cycle).
  - LEN==0 -> DONE directly.
  - ERR is reachable only via the length overflow check.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERR), BYTES_PER_WORD=4, LEN_W=16.
- One sub-module, imem_loader_word_asm: 2-bit byte counter plus 32-bit shift register with a word_valid output.

Test Plan:
- Nominal: start; bytes 02 00 13 00 70 00 93 09 60 07 9C with in_valid held high -> imem_we at addr0=0x00700013 and addr1=0x07600993; done pulse; cpu_hold 1->0; words_loaded=2; error=0.
- Bad checksum: same stream with last byte 9D -> both writes occur, error=1, cpu_hold stays 1, no done pulse.
- Overflow: LEN bytes 21 00 (33 words > 32) -> ERR right after the LEN_HI transfer; imem_we never asserted; in_ready=0.
- Empty image: LEN bytes 00 00, CSUM 00 -> done with words_loaded=0, no imem_we. With macro off, no CSUM byte is sent.
- Backpressure/gaps: nominal stream with in_valid toggling every other cycle, and start pulsed mid-load -> identical writes and result; the mid-load start is ignored.
- Reset mid-load: assert reset after the 7th byte -> only addr0 written; all outputs at reset values; a subsequent nominal load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Build option IMEM_LOADER_CSUM_EN enables the trailing XOR checksum byte.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic accepts_bytes(input state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: four bytes in (b0 first), one 32-bit word out.
// word_valid is high for the single cycle after the fourth byte is accepted.
module imem_loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_reg;
    logic [31:0] shift_reg;
    logic        valid_reg;

    assign last_byte  = (cnt_reg == 2'(BYTES_PER_WORD - 1));
    assign word       = shift_reg;
    assign word_valid = valid_reg;

    // Bytes enter at the top and shift down, so b0 ends up in bits [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= byte_en && last_byte && !clear;
            if (clear) begin
                cnt_reg <= '0;
            end else if (byte_en) begin
                shift_reg <= {byte_in, shift_reg[31:8]};
                cnt_reg   <= cnt_reg + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: LEN_LO, LEN_HI, LEN words, optional CSUM.
// Define IMEM_LOADER_CSUM_EN to require and verify the trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    state_t             state_reg, state_next;
    logic [7:0]         len_lo_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   len_in;
    logic [15:0]        words_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               done_reg;
    logic               xfer;
    logic               start_ok;
    logic               word_done;
    logic               last_byte;
    logic               asm_valid;
    logic [31:0]        asm_word;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]         xor_reg;
`endif

    assign in_ready  = accepts_bytes(state_reg);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
    assign len_in    = {in_data, len_lo_reg};
    assign word_done = (state_reg == DATA) && xfer && last_byte;

    imem_loader_word_asm u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_en    ((state_reg == DATA) && xfer),
        .byte_in    (in_data),
        .last_byte  (last_byte),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) state_next = LEN0;
            end
            LEN0: begin
                if (xfer) state_next = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    if (len_in > LEN_W'(DEPTH_WORDS)) begin
                        state_next = ERR;
                    end else if (len_in == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_done && (words_reg + 16'd1 == len_reg)) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CHECK: begin
                if (xfer) state_next = (in_data == xor_reg) ? DONE : ERR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            len_lo_reg <= '0;
            len_reg    <= '0;
            words_reg  <= '0;
            addr_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == DONE) && (state_reg != DONE);
            if (start_ok) words_reg <= '0;
            if (xfer && state_reg == LEN0) len_lo_reg <= in_data;
            if (xfer && state_reg == LEN1) len_reg <= len_in;
            // Address and count update together so the write cycle presents both.
            if (word_done) begin
                addr_reg  <= words_reg[ADDR_W-1:0];
                words_reg <= words_reg + 16'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Running XOR covers the length bytes and every data byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_reg <= '0;
        end else if (start_ok) begin
            xor_reg <= '0;
        end else if (xfer && (state_reg == LEN0 || state_reg == LEN1 || state_reg == DATA)) begin
            xor_reg <= xor_reg ^ in_data;
        end
    end
`endif

    assign imem_we      = asm_valid;
    assign imem_addr    = addr_reg;
    assign imem_wdata   = asm_word;
    assign cpu_hold     = (state_reg != DONE);
    assign busy         = accepts_bytes(state_reg);
    assign done         = done_reg;
    assign error        = (state_reg == ERR);
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven loads plus mid-load start and reset sequences.
// Stream expectations follow IMEM_LOADER_CSUM_EN (checksum byte present or not).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write/done monitor: cumulative counts, only written here.
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [4:0]  wr_addr [64];
    logic [31:0] wr_data [64];

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    typedef struct {
        logic [95:0] stream;   // first byte in bits [95:88]
        int          n;
        bit          gap;
        int          exp_wr;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int guard;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: got in_ready=0 expected 1 for byte %0h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic check_result(input string tag, input int base_w, input int base_d, input vec_t v);
        chk({tag, "_writes"}, 32'(wr_cnt - base_w), 32'(v.exp_wr));
        if (v.exp_wr >= 1) begin
            chk({tag, "_addr0"}, 32'(wr_addr[base_w]), 32'd0);
            chk({tag, "_data0"}, wr_data[base_w], v.d0);
        end
        if (v.exp_wr >= 2) begin
            chk({tag, "_addr1"}, 32'(wr_addr[base_w + 1]), 32'd1);
            chk({tag, "_data1"}, wr_data[base_w + 1], v.d1);
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt - base_d), 32'(v.exp_done));
        chk({tag, "_error"}, 32'(error), 32'(v.exp_err));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!v.exp_done));
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(v.exp_words));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input int i, input int mid_start_after);
        int   base_w;
        int   base_d;
        vec_t v;
        logic [95:0] s;
        v      = vecs[i];
        s      = v.stream;
        base_w = wr_cnt;
        base_d = done_cnt;
        pulse_start();
        chk($sformatf("v%0d_busy_after_start", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_hold_after_start", i), 32'(cpu_hold), 32'd1);
        for (int k = 0; k < v.n; k++) begin
            if (k == mid_start_after) pulse_start();
            send_byte(s[95 - 8*k -: 8], v.gap);
        end
        repeat (4) @(negedge clk);
        #1;
        check_result($sformatf("v%0d", i), base_w, base_d, v);
        $display("load vec %0d: writes=%0d done=%0b error=%0b words=%0d",
                 i, wr_cnt - base_w, done_cnt - base_d, error, words_loaded);
    endtask

    initial begin
`ifdef IMEM_LOADER_CSUM_EN
        vecs[0] = '{96'h02_00_13_00_70_00_93_09_60_07_9C_00, 11, 0, 2, 32'h00700013, 32'h07600993, 1, 0, 2};
        vecs[1] = '{96'h02_00_13_00_70_00_93_09_60_07_9D_00, 11, 0, 2, 32'h00700013, 32'h07600993, 0, 1, 2};
        vecs[2] = '{96'h21_00_00_00_00_00_00_00_00_00_00_00,  2, 0, 0, 32'h0, 32'h0, 0, 1, 0};
        vecs[3] = '{96'h00_00_00_00_00_00_00_00_00_00_00_00,  3, 0, 0, 32'h0, 32'h0, 1, 0, 0};
        vecs[4] = '{96'h01_00_EF_BE_AD_DE_23_00_00_00_00_00,  7, 0, 1, 32'hDEADBEEF, 32'h0, 1, 0, 1};
        vecs[5] = '{96'h02_00_13_00_70_00_93_09_60_07_9C_00, 11, 1, 2, 32'h00700013, 32'h07600993, 1, 0, 2};
`else
        vecs[0] = '{96'h02_00_13_00_70_00_93_09_60_07_00_00, 10, 0, 2, 32'h00700013, 32'h07600993, 1, 0, 2};
        vecs[1] = '{96'h01_00_EF_BE_AD_DE_00_00_00_00_00_00,  6, 1, 1, 32'hDEADBEEF, 32'h0, 1, 0, 1};
        vecs[2] = '{96'h21_00_00_00_00_00_00_00_00_00_00_00,  2, 0, 0, 32'h0, 32'h0, 0, 1, 0};
        vecs[3] = '{96'h00_00_00_00_00_00_00_00_00_00_00_00,  2, 0, 0, 32'h0, 32'h0, 1, 0, 0};
        vecs[4] = '{96'h01_00_EF_BE_AD_DE_00_00_00_00_00_00,  6, 0, 1, 32'hDEADBEEF, 32'h0, 1, 0, 1};
        vecs[5] = '{96'h02_00_13_00_70_00_93_09_60_07_00_00, 10, 1, 2, 32'h00700013, 32'h07600993, 1, 0, 2};
`endif
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, -1);

        // Start pulsed mid-load must be ignored.
        run_vec(5, 5);

        // Reset after the 7th byte: first word already written, nothing after.
        begin
            int          base_w;
            logic [95:0] s;
            s      = vecs[0].stream;
            base_w = wr_cnt;
            pulse_start();
            for (int k = 0; k < 7; k++) send_byte(s[95 - 8*k -: 8], 1'b0);
            reset = 1'b1;
            #1;
            check_reset_vals("midrst");
            repeat (3) @(negedge clk);
            #1;
            chk("midrst_writes", 32'(wr_cnt - base_w), 32'd1);
            chk("midrst_addr0", 32'(wr_addr[base_w]), 32'd0);
            chk("midrst_data0", wr_data[base_w], 32'h00700013);
            $display("reset mid-load: writes=%0d", wr_cnt - base_w);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            run_vec(0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
